// File: rtl/vdac_gamma_lut.sv
// Per-channel gamma lookup for a VDAC: a 2-cycle pixel pipeline with three transfer modes and
// runtime-writable tables that are reloaded with a saturating linear ramp after every reset.
module vdac_gamma_lut #(
    parameter int unsigned IN_W      = 5,
    parameter int unsigned OUT_W     = 8,
    parameter int unsigned NCH       = 3,
    parameter int unsigned FULL_CODE = 24
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic [1:0]                               mode_i,
    input  logic                                     blank_i,
    input  logic                                     in_vld_i,
    input  logic [NCH*IN_W-1:0]                      in_data_i,
    output logic                                     out_vld_o,
    output logic [NCH*OUT_W-1:0]                     out_data_o,
    input  logic                                     wr_en_i,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] wr_ch_i,
    input  logic [IN_W-1:0]                          wr_addr_i,
    input  logic [OUT_W-1:0]                         wr_data_i,
    output logic                                     wr_rdy_o,
    output logic                                     init_done_o
);

    localparam int unsigned Depth = 2 ** IN_W;
    localparam int unsigned PW    = IN_W + OUT_W;
    localparam logic [PW-1:0]   MaxCodeW = PW'({OUT_W{1'b1}});
    localparam logic [PW-1:0]   FullW    = PW'(FULL_CODE);
    localparam logic [IN_W-1:0] AddrMax  = '1;

    typedef enum logic {
        StInit,
        StRun
    } state_e;

    // Product is formed at IN_W+OUT_W bits so it can never overflow before the clamp.
    function automatic logic [OUT_W-1:0] lin_f(input logic [IN_W-1:0] a);
        logic [PW-1:0] prod;
        logic [PW-1:0] quo;
        logic [OUT_W-1:0] res;
        prod = PW'(a) * MaxCodeW;
        quo  = prod / FullW;
        if (quo > MaxCodeW) begin
            res = '1;
        end else begin
            res = quo[OUT_W-1:0];
        end
        return res;
    endfunction

    state_e            state_q, state_d;
    logic [IN_W-1:0]   init_addr_q, init_addr_d;

    logic [OUT_W-1:0]  lut_q [NCH][Depth];

    logic                 s1_vld_q;
    logic                 s1_blank_q;
    logic [1:0]           s1_mode_q;
    logic [NCH*IN_W-1:0]  s1_data_q;

    logic                 out_vld_q;
    logic [NCH*OUT_W-1:0] out_data_q, out_data_d;

    logic                 run;
    logic                 init_we;
    logic                 user_we;
    logic [31:0]          wr_ch_ext;
    logic [OUT_W-1:0]     init_val;

    assign run         = (state_q == StRun);
    assign init_we     = (state_q == StInit);
    assign wr_ch_ext   = 32'(wr_ch_i);
    // Writes to a non-existent channel are silently discarded.
    assign user_we     = wr_en_i && run && (wr_ch_ext < NCH);
    assign init_val    = lin_f(init_addr_q);

    assign wr_rdy_o    = run;
    assign init_done_o = run;
    assign out_vld_o   = out_vld_q;
    assign out_data_o  = out_data_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StInit;
            init_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        case (state_q)
            StInit: begin
                init_addr_d = init_addr_q + 1'b1;
                if (init_addr_q == AddrMax) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                state_d = StRun;
            end
        endcase
    end

    // Table RAM: no reset, the INIT sweep rewrites every entry after each reset.
    always_ff @(posedge clk_i) begin
        for (int unsigned c = 0; c < NCH; c++) begin
            if (init_we) begin
                lut_q[c][init_addr_q] <= init_val;
            end else if (user_we && (wr_ch_ext == c)) begin
                lut_q[c][wr_addr_i] <= wr_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_vld_q   <= 1'b0;
            s1_blank_q <= 1'b0;
            s1_mode_q  <= 2'b00;
            s1_data_q  <= '0;
        end else begin
            s1_vld_q   <= in_vld_i;
            s1_blank_q <= blank_i;
            s1_mode_q  <= mode_i;
            s1_data_q  <= in_data_i;
        end
    end

    // The table read is combinational, so a same-edge write is seen only by the next pixel.
    always_comb begin
        logic [IN_W-1:0]  pix_x;
        logic [OUT_W-1:0] pix_y;
        out_data_d = '0;
        pix_x      = '0;
        pix_y      = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            pix_x = s1_data_q[c*IN_W +: IN_W];
            case (s1_mode_q)
                2'b01:   pix_y = OUT_W'(pix_x) << (OUT_W - IN_W);
                2'b10:   pix_y = lin_f(pix_x);
                default: pix_y = lut_q[c][pix_x];
            endcase
            out_data_d[c*OUT_W +: OUT_W] = pix_y;
        end
        if (s1_blank_q || !run) begin
            out_data_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
        end else begin
            out_vld_q  <= s1_vld_q;
            out_data_q <= out_data_d;
        end
    end

endmodule

// File: tb/tb_vdac_gamma_lut.sv
// Randomised bench for vdac_gamma_lut: a cycle-level behavioural model is compared against the
// DUT every cycle, with literal pixel expectations pinning the model at key points.
module tb_vdac_gamma_lut;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode = 2'b00;
    logic        blank = 1'b0;
    logic        in_vld = 1'b0;
    logic [14:0] in_data = '0;
    logic        out_vld;
    logic [23:0] out_data;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_ch = '0;
    logic [4:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_rdy;
    logic        init_done;

    int n_checks = 0;
    int n_fail   = 0;

    vdac_gamma_lut dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .mode_i      (mode),
        .blank_i     (blank),
        .in_vld_i    (in_vld),
        .in_data_i   (in_data),
        .out_vld_o   (out_vld),
        .out_data_o  (out_data),
        .wr_en_i     (wr_en),
        .wr_ch_i     (wr_ch),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .wr_rdy_o    (wr_rdy),
        .init_done_o (init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lin_m(input int a);
        int v;
        v = (a * 255) / 24;
        return (v > 255) ? 255 : v;
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        vld;
        logic        blank;
        logic [1:0]  mode;
        logic [14:0] data;
    } pix_t;

    pix_t        m_s1;
    logic        m_done;
    int          m_cnt;
    int          m_lut [3][32];
    logic        m_vld;
    logic [23:0] m_data;

    initial begin
        m_s1 = '0; m_done = 1'b0; m_cnt = 0; m_vld = 1'b0; m_data = '0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_s1 = '0; m_done = 1'b0; m_cnt = 0; m_vld = 1'b0; m_data = '0;
            end else begin
                m_vld  = m_s1.vld;
                m_data = '0;
                if (m_done && !m_s1.blank) begin
                    for (int c = 0; c < 3; c++) begin
                        int x, v;
                        x = int'(m_s1.data[c*5 +: 5]);
                        case (m_s1.mode)
                            2'b01:   v = x * 8;
                            2'b10:   v = lin_m(x);
                            default: v = m_lut[c][x];
                        endcase
                        m_data[c*8 +: 8] = 8'(v);
                    end
                end
                if (m_done && wr_en && wr_ch < 2'd3) m_lut[wr_ch][wr_addr] = int'(wr_data);
                m_s1 = '{vld: in_vld, blank: blank, mode: mode, data: in_data};
                if (!m_done) begin
                    m_cnt++;
                    if (m_cnt == 32) begin
                        m_done = 1'b1;
                        for (int c = 0; c < 3; c++)
                            for (int a = 0; a < 32; a++) m_lut[c][a] = lin_m(a);
                    end
                end
            end
        end
    end

    // Every-cycle comparison, sampled well after the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            check("out_vld", 32'(out_vld), 32'(m_vld));
            if (m_vld || rst) check("out_data", 32'(out_data), 32'(m_data));
            check("init_done", 32'(init_done), 32'(m_done));
            check("wr_rdy", 32'(wr_rdy), 32'(m_done));
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        in_vld = 1'b0; blank = 1'b0; wr_en = 1'b0;
    endtask

    // Called right after rst falls at a negedge; expects init_done 32 rising edges later.
    task automatic wait_init();
        int seen;
        seen = 0;
        for (int i = 1; i <= 40 && seen == 0; i++) begin
            @(posedge clk);
            #1;
            if (init_done) begin
                seen  = i;
                wr_en = 1'b0;
            end else begin
                in_vld  = i[0];
                in_data = 15'($urandom);
                mode    = 2'($urandom_range(0, 3));
                wr_en   = 1'b1;
                wr_ch   = 2'd1;
                wr_addr = 5'd7;
                wr_data = 8'h33;
            end
        end
        idle();
        check("init_latency", 32'(seen), 32'd32);
        check("wr_rdy_after_init", 32'(wr_rdy), 32'd1);
    endtask

    task automatic send_px(input logic [1:0] m, input logic b, input logic [14:0] d,
                           output logic [23:0] got, output logic gv);
        @(negedge clk);
        mode = m; blank = b; in_data = d; in_vld = 1'b1;
        @(negedge clk);
        in_vld = 1'b0; blank = 1'b0;
        @(posedge clk);
        #1;
        got = out_data;
        gv  = out_vld;
    endtask

    task automatic rand_cycle();
        @(negedge clk);
        in_vld  = ($urandom_range(0, 3) != 0);
        mode    = 2'($urandom_range(0, 3));
        blank   = ($urandom_range(0, 15) == 0);
        in_data = 15'($urandom);
        wr_en   = ($urandom_range(0, 3) == 0);
        wr_ch   = 2'($urandom_range(0, 3));
        wr_addr = 5'($urandom_range(0, 31));
        wr_data = 8'($urandom);
    endtask

    logic [23:0] got;
    logic        gv;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_out_vld", 32'(out_vld), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_wr_rdy", 32'(wr_rdy), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        rst = 1'b0;
        wait_init();

        // Same x=5 pixel back to back in three modes.
        @(negedge clk); in_vld = 1'b1; mode = 2'b01; in_data = {5'd5, 5'd5, 5'd5};
        @(negedge clk); mode = 2'b10;
        @(posedge clk); #1; check("mode01_x5", 32'(out_data), 32'h282828);
        @(negedge clk); mode = 2'b00;
        @(posedge clk); #1; check("mode10_x5", 32'(out_data), 32'h353535);
        @(negedge clk); idle();
        @(posedge clk); #1; check("mode00_x5", 32'(out_data), 32'h353535);

        send_px(2'b00, 1'b0, {5'd2, 5'd2, 5'd2}, got, gv);
        check("lut_x2", 32'(got), 32'h151515);
        send_px(2'b11, 1'b0, {5'd24, 5'd24, 5'd24}, got, gv);
        check("lut_x24_sat", 32'(got), 32'hFFFFFF);
        send_px(2'b10, 1'b0, {5'd31, 5'd0, 5'd1}, got, gv);
        check("lin_mixed", 32'(got), 32'hFF000A);

        for (int x = 0; x < 32; x++) begin
            @(negedge clk);
            in_vld = 1'b1; mode = 2'b00; in_data = {5'(x), 5'(x), 5'(x)};
        end
        @(negedge clk); idle();
        repeat (2) @(negedge clk);

        // Write lands on the same edge the G=7 pixel is looked up.
        @(negedge clk); in_vld = 1'b1; mode = 2'b00; in_data = {5'd7, 5'd7, 5'd7};
        @(negedge clk); wr_en = 1'b1; wr_ch = 2'd1; wr_addr = 5'd7; wr_data = 8'hAA;
        @(posedge clk); #1; check("collision_old", 32'(out_data), 32'h4A4A4A);
        @(negedge clk); idle();
        @(posedge clk); #1; check("collision_new", 32'(out_data), 32'h4AAA4A);
        @(negedge clk); wr_en = 1'b1; wr_ch = 2'd3; wr_addr = 5'd7; wr_data = 8'h55;
        @(negedge clk); idle();
        send_px(2'b00, 1'b0, {5'd7, 5'd7, 5'd7}, got, gv);
        check("drop_ch3", 32'(got), 32'h4AAA4A);

        send_px(2'b01, 1'b1, 15'h7FFF, got, gv);
        check("blank_vld", 32'(gv), 32'd1);
        check("blank_data", 32'(got), 32'd0);

        repeat (1500) rand_cycle();
        @(negedge clk); idle();

        @(negedge clk); wr_en = 1'b1; wr_ch = 2'd1; wr_addr = 5'd7; wr_data = 8'hAA;
        @(negedge clk); idle();
        send_px(2'b00, 1'b0, {5'd7, 5'd7, 5'd7}, got, gv);
        check("custom_g", 32'(got[15:8]), 32'hAA);

        repeat (6) rand_cycle();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrun_rst_vld", 32'(out_vld), 32'd0);
        check("midrun_rst_data", 32'(out_data), 32'd0);
        check("midrun_rst_rdy", 32'(wr_rdy), 32'd0);
        check("midrun_rst_done", 32'(init_done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_init();
        send_px(2'b00, 1'b0, {5'd7, 5'd7, 5'd7}, got, gv);
        check("restored_x7", 32'(got), 32'h4A4A4A);

        repeat (300) rand_cycle();
        @(negedge clk); idle();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
